// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and defaults for the PC sequencer.
// State encoding, decoder flag bundle and exit-action selection.
package pc_seq_pkg;

   localparam int         PC_W_DEF        = 8;
   localparam int         JA_W_DEF        = 5;
   localparam int         STACK_DEPTH_DEF = 4;
   localparam logic [7:0] RESET_PC_DEF    = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      ACT_INC,
      ACT_JUMP,
      ACT_CALL,
      ACT_RET,
      ACT_HALT
   } act_e;

   typedef struct packed {
      logic jump;
      logic halt;
      logic call;
      logic ret;
   } dec_flags_t;

   // Resolve the latched flags into one action, halt > ret > call > jump.
   // Without a stack, call degrades to jump and ret to increment.
   function automatic act_e pick_act(
      input dec_flags_t f,
      input bit         stack_en
   );
      act_e a;
      a = ACT_INC;
      if (f.halt) begin
         a = ACT_HALT;
      end else if (f.ret) begin
         a = stack_en ? ACT_RET : ACT_INC;
      end else if (f.call) begin
         a = stack_en ? ACT_CALL : ACT_JUMP;
      end else if (f.jump) begin
         a = ACT_JUMP;
      end
      return a;
   endfunction

endpackage

// File: rtl/pc_call_stack.sv
// pc_call_stack: small LIFO of return addresses.
// Pushes when full and pops when empty are dropped and strobed.
module pc_call_stack
   import pc_seq_pkg::*;
#(
   parameter  int DEPTH = STACK_DEPTH_DEF,
   parameter  int W     = PC_W_DEF,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  top,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic          ovf,
   output logic          unf
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign ovf   = push & full;
   assign unf   = pop & empty;

   // Present the most recently pushed entry.
   always_comb begin
      top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i + 1) == cnt_q) begin
            top = mem_q[i];
         end
      end
   end

   // Write at the fill level on push, shrink on pop.
   always_comb begin
      mem_d = mem_q;
      cnt_d = cnt_q;
      if (push && !full) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == cnt_q) begin
               mem_d[i] = din;
            end
         end
         cnt_d = cnt_q + CW'(1);
      end else if (pop && !empty) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Storage and fill level; reset empties the stack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute sequencer owning the PC.
// Define PC_CALL_STACK_EN to add the call/return stack.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              PC_W        = PC_W_DEF,
   parameter int              JA_W        = JA_W_DEF,
   parameter int              STACK_DEPTH = STACK_DEPTH_DEF,
   parameter logic [PC_W-1:0] RESET_PC    = PC_W'(RESET_PC_DEF)
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic            dec_jump,
   input  logic            dec_halt,
   input  logic            dec_call,
   input  logic            dec_ret,
   input  logic [JA_W-1:0] dec_addr,
   input  logic            exec_stall,
   output logic            ir_load,
   output logic            exec_en,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic            stack_err
);

`ifdef PC_CALL_STACK_EN
   localparam bit STACK_EN = 1'b1;
`else
   localparam bit STACK_EN = 1'b0;
`endif

   state_e          state_q;
   state_e          state_d;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   dec_flags_t      dec_q;
   dec_flags_t      dec_d;
   logic [JA_W-1:0] tgt_q;
   logic [JA_W-1:0] tgt_d;
   logic            err_q;
   logic            err_d;

   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] tgt_ext;
   act_e            act;
   logic            push_req;
   logic            pop_req;
   logic [PC_W-1:0] stk_top;
   logic            stk_empty;
   logic            stk_ovf;
   logic            stk_unf;

   assign pc_inc  = pc_q + 1'b1;
   assign tgt_ext = PC_W'(tgt_q);
   assign act     = pick_act(dec_q, STACK_EN);

`ifdef PC_CALL_STACK_EN
   logic                             unused_full;
   logic [$clog2(STACK_DEPTH+1)-1:0] unused_count;

   pc_call_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (PC_W)
   ) u_stack (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (push_req),
      .pop   (pop_req),
      .din   (pc_inc),
      .top   (stk_top),
      .full  (unused_full),
      .empty (stk_empty),
      .count (unused_count),
      .ovf   (stk_ovf),
      .unf   (stk_unf)
   );
`else
   logic unused_stk;

   assign stk_top    = '0;
   assign stk_empty  = 1'b1;
   assign stk_ovf    = 1'b0;
   assign stk_unf    = 1'b0;
   assign unused_stk = ^{push_req, pop_req, STACK_DEPTH};
`endif

   // Outputs decode from state; ir_load follows ack inside FETCH.
   assign imem_req  = (state_q == ST_FETCH);
   assign imem_addr = imem_req ? pc_q : '0;
   assign ir_load   = imem_req & imem_ack;
   assign exec_en   = (state_q == ST_EXEC);
   assign halted    = (state_q == ST_HALT);
   assign pc        = pc_q;
   assign stack_err = err_q & STACK_EN;

   // Next state, PC update on EXEC exit, decoder flag capture.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      dec_d    = dec_q;
      tgt_d    = tgt_q;
      push_req = 1'b0;
      pop_req  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (imem_ack) begin
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            dec_d.jump = dec_jump;
            dec_d.halt = dec_halt;
            dec_d.call = dec_call;
            dec_d.ret  = dec_ret;
            tgt_d      = dec_addr;
            state_d    = ST_EXEC;
         end
         ST_EXEC: begin
            if (!exec_stall) begin
               state_d = ST_FETCH;
               unique case (act)
                  ACT_HALT: begin
                     state_d = ST_HALT;
                  end
                  ACT_RET: begin
                     pop_req = 1'b1;
                     pc_d    = stk_empty ? pc_inc : stk_top;
                  end
                  ACT_CALL: begin
                     push_req = 1'b1;
                     pc_d     = tgt_ext;
                  end
                  ACT_JUMP: begin
                     pc_d = tgt_ext;
                  end
                  default: begin
                     pc_d = pc_inc;
                  end
               endcase
            end
         end
         ST_HALT: begin
            if (start) begin
               pc_d    = pc_inc;
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sticky error collects dropped pushes and pops.
   always_comb begin
      err_d = err_q | stk_ovf | stk_unf;
   end

   // State, PC, latched decode and error registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         dec_q   <= '0;
         tgt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         dec_q   <= dec_d;
         tgt_q   <= tgt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus random stimulus against a
// cycle-level behavioural model of the sequencer.
`timescale 1ns/1ps
module tb_pc_sequencer;

   localparam int PC_W = 8;
   localparam int JA_W = 5;
   localparam int DEPTH = 4;

   localparam int M_IDLE   = 0;
   localparam int M_FETCH  = 1;
   localparam int M_DECODE = 2;
   localparam int M_EXEC   = 3;
   localparam int M_HALT   = 4;

   logic            CLK = 1'b0;
   logic            RST_N = 1'b0;
   logic            start = 1'b0;
   logic            imem_ack = 1'b0;
   logic            dec_jump = 1'b0;
   logic            dec_halt = 1'b0;
   logic            dec_call = 1'b0;
   logic            dec_ret = 1'b0;
   logic [JA_W-1:0] dec_addr = '0;
   logic            exec_stall = 1'b0;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            ir_load;
   logic            exec_en;
   logic [PC_W-1:0] pc;
   logic            halted;
   logic            stack_err;

   int tests = 0;
   int fails = 0;

   int m_st;
   int m_pc;
   bit m_j, m_h, m_c, m_r;
   int m_tgt;
   bit m_err;
`ifdef PC_CALL_STACK_EN
   int m_stk[$];
`endif

   int cyc = 0;
   int fa[$];
   int fc[$];
   int ecnt, icnt, rq5;

   always #5 CLK = ~CLK;

   pc_sequencer dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .start      (start),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .dec_jump   (dec_jump),
      .dec_halt   (dec_halt),
      .dec_call   (dec_call),
      .dec_ret    (dec_ret),
      .dec_addr   (dec_addr),
      .exec_stall (exec_stall),
      .ir_load    (ir_load),
      .exec_en    (exec_en),
      .pc         (pc),
      .halted     (halted),
      .stack_err  (stack_err)
   );

   initial begin
      #1ms;
      $display("FAIL watchdog: sim time expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic m_reset();
      m_st  = M_IDLE;
      m_pc  = 0;
      m_j   = 0;
      m_h   = 0;
      m_c   = 0;
      m_r   = 0;
      m_tgt = 0;
      m_err = 0;
`ifdef PC_CALL_STACK_EN
      m_stk.delete();
`endif
   endtask

   task automatic m_exit();
      m_st = M_FETCH;
      if (m_h) begin
         m_st = M_HALT;
      end else if (m_r) begin
`ifdef PC_CALL_STACK_EN
         if (m_stk.size() == 0) begin
            m_err = 1;
            m_pc  = (m_pc + 1) % 256;
         end else begin
            m_pc = m_stk.pop_back();
         end
`else
         m_pc = (m_pc + 1) % 256;
`endif
      end else if (m_c) begin
`ifdef PC_CALL_STACK_EN
         if (m_stk.size() == DEPTH) m_err = 1;
         else m_stk.push_back((m_pc + 1) % 256);
`endif
         m_pc = m_tgt;
      end else if (m_j) begin
         m_pc = m_tgt;
      end else begin
         m_pc = (m_pc + 1) % 256;
      end
   endtask

   task automatic m_step();
      case (m_st)
         M_IDLE:  if (start) m_st = M_FETCH;
         M_FETCH: if (imem_ack) m_st = M_DECODE;
         M_DECODE: begin
            m_j   = dec_jump;
            m_h   = dec_halt;
            m_c   = dec_call;
            m_r   = dec_ret;
            m_tgt = int'(dec_addr);
            m_st  = M_EXEC;
         end
         M_EXEC: if (!exec_stall) m_exit();
         M_HALT: begin
            if (start) begin
               m_pc = (m_pc + 1) % 256;
               m_st = M_FETCH;
            end
         end
         default: m_st = M_IDLE;
      endcase
   endtask

   task automatic check_all();
      chk("imem_req", imem_req, m_st == M_FETCH);
      if (m_st == M_FETCH) chk("imem_addr", imem_addr, m_pc);
      if (m_st == M_IDLE) chk("idle_addr", imem_addr, 0);
      chk("ir_load", ir_load, (m_st == M_FETCH) && imem_ack);
      chk("exec_en", exec_en, m_st == M_EXEC);
      chk("halted", halted, m_st == M_HALT);
      chk("pc", pc, m_pc);
      chk("stack_err", stack_err, m_err);
   endtask

   task automatic tick();
      #1;
      check_all();
      if (ir_load) begin
         fa.push_back(int'(imem_addr));
         fc.push_back(cyc);
         icnt++;
      end
      if (exec_en) ecnt++;
      if (imem_req && imem_addr == 8'h05) rq5++;
      @(posedge CLK);
      if (RST_N) m_step();
      cyc++;
      @(negedge CLK);
   endtask

   task automatic run_to(input string nm, input int p, input int st,
                         input int budget);
      int n;
      n = 0;
      while (!(m_pc == p && m_st == st) && n < budget) begin
         tick();
         n++;
      end
      chk(nm, (m_pc == p && m_st == st), 1);
   endtask

   task automatic clear_flags();
      dec_jump = 0;
      dec_halt = 0;
      dec_call = 0;
      dec_ret  = 0;
   endtask

   initial begin
      m_reset();
      repeat (2) @(negedge CLK);
      #1;
      chk("rst_pc", pc, 8'h00);
      chk("rst_req", imem_req, 0);
      chk("rst_exec", exec_en, 0);
      chk("rst_halted", halted, 0);
      @(negedge CLK);
      RST_N = 1;

      // sequential fetch at a 3-cycle cadence
      start = 1;
      tick();
      start    = 0;
      imem_ack = 1;
      fa.delete();
      fc.delete();
      ecnt = 0;
      repeat (9) tick();
      chk("t1_fetches", fa.size(), 3);
      if (fa.size() >= 3) begin
         chk("t1_a0", fa[0], 8'h00);
         chk("t1_a1", fa[1], 8'h01);
         chk("t1_a2", fa[2], 8'h02);
         chk("t1_gap0", fc[1] - fc[0], 3);
         chk("t1_gap1", fc[2] - fc[1], 3);
      end
      chk("t1_exec", ecnt, 3);

      // ack delayed two cycles at PC 05
      run_to("t2_reach", 5, M_FETCH, 50);
      rq5      = 0;
      icnt     = 0;
      imem_ack = 0;
      tick();
      tick();
      imem_ack = 1;
      tick();
      chk("t2_req_hold", rq5, 3);
      chk("t2_irload", icnt, 1);

      // jump with two stall cycles at PC 40
      run_to("t3_reach", 8'h40, M_DECODE, 400);
      dec_jump = 1;
      dec_addr = 5'h13;
      tick();
      clear_flags();
      dec_addr   = 5'h07;
      exec_stall = 1;
      ecnt       = 0;
      tick();
      tick();
      #1 chk("t3_pc_stall", pc, 8'h40);
      exec_stall = 0;
      tick();
      chk("t3_exec", ecnt, 3);
      #1 chk("t3_target", imem_addr, 8'h13);

      // wrap from FF, then halt and restart
      run_to("t4_reach", 8'hFF, M_FETCH, 2000);
      repeat (3) tick();
      #1 chk("t4_wrap", imem_addr, 8'h00);
      tick();
      dec_halt = 1;
      tick();
      clear_flags();
      tick();
      #1 chk("t4_halted", halted, 1);
      chk("t4_pc_hold", pc, 8'h00);
      tick();
      tick();
      start = 1;
      tick();
      start = 0;
      #1 chk("t4_resume", imem_addr, 8'h01);

      // asynchronous reset while waiting for ack
      imem_ack = 0;
      tick();
      #2 RST_N = 0;
      #1;
      chk("t5_req", imem_req, 0);
      chk("t5_pc", pc, 8'h00);
      m_reset();
      @(negedge CLK);
      RST_N    = 1;
      imem_ack = 1;
      repeat (3) tick();
      #1 chk("t5_idle", imem_req, 0);

`ifdef PC_CALL_STACK_EN
      // call/return and nested-call overflow
      start = 1;
      tick();
      start = 0;
      run_to("t6_reach", 8'h20, M_DECODE, 400);
      dec_call = 1;
      dec_addr = 5'h0A;
      tick();
      clear_flags();
      tick();
      #1 chk("t6_call", imem_addr, 8'h0A);
      tick();
      dec_ret = 1;
      tick();
      clear_flags();
      tick();
      #1 chk("t6_ret", imem_addr, 8'h21);
      for (int k = 0; k < 5; k++) begin
         tick();
         dec_call = 1;
         dec_addr = JA_W'(k + 1);
         tick();
         clear_flags();
         tick();
         #1;
         chk("t6_err", stack_err, k == 4);
         chk("t6_pc", pc, k + 1);
      end
`endif

      // random stimulus
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            #2 RST_N = 0;
            #1 chk("rnd_rst_req", imem_req, 0);
            m_reset();
            @(negedge CLK);
            RST_N = 1;
         end
         start      = ($urandom_range(0, 3) == 0);
         imem_ack   = ($urandom_range(0, 2) != 0);
         exec_stall = ($urandom_range(0, 2) == 0);
         dec_halt   = ($urandom_range(0, 9) == 0);
         dec_jump   = ($urandom_range(0, 3) == 0);
         dec_call   = ($urandom_range(0, 3) == 0);
         dec_ret    = ($urandom_range(0, 3) == 0);
         dec_addr   = JA_W'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
